signal_mean: RTL
================

# signal_mean

Upstream stage of the `frequency` block. It produces the `mean` threshold that `frequency` compares each ADC sample against. It averages the 12-bit ADC sample stream over fixed power-of-two windows and tracks per-window minimum, maximum and peak-to-peak amplitude. Every completed window updates the outputs, which hold until the next window completes. It sits between the ADC capture logic and `frequency`/VGA overlay; `mean` connects directly to `frequency.mean`.

## Interface

Parameters:
- `DATA_W`, 12, ADC sample width.
- `MEAN_W`, 14, mean output width; the value is zero-extended from `DATA_W`.
- `LOG2_WIN`, 10, the window is 2^LOG2_WIN valid samples.
- `SETTLE_N`, 8, valid samples discarded after reset (ADC pipeline flush).
- `MIN_VPP`, 12'd64, peak-to-peak threshold below which `low_amp` asserts.

Ports:
- `clk`, in, 1, system clock (50 MHz).
- `rst_n`, in, 1, reset; synchronous, active-low.
- `sample_valid`, in, 1, qualifies `data` on this clock edge.
- `data`, in, DATA_W, ADC sample, unsigned.
- `mean`, out, MEAN_W, registered window average.
- `max_out`, out, DATA_W, largest sample in the last window.
- `min_out`, out, DATA_W, smallest sample in the last window.
- `vpp`, out, DATA_W, `max_out - min_out`.
- `mean_valid`, out, 1, one-cycle pulse when the outputs update.
- `locked`, out, 1, high once the first window has completed.
- `low_amp`, out, 1, `vpp < MIN_VPP`, registered with the other outputs.

Clock and reset are fixed: one clock, with reset synchronous and active-low.

## Operation

The state machine has three states: SETTLE, ACCUM and COMMIT.
- SETTLE:
  - Counts valid samples and discards them.
  - When the `SETTLE_N`-th valid sample is seen, goes to ACCUM with the accumulator cleared.
  - When `SETTLE_N` = 0, goes to ACCUM directly out of reset.
- ACCUM, on each valid sample:
  - `acc += data`.
  - `run_max = max(run_max, data)` and `run_min = min(run_min, data)`.
  - `cnt++`.
  - When the valid sample with `cnt == 2^LOG2_WIN-1` arrives, it is included in the sums and the block goes to COMMIT.
- COMMIT (exactly one cycle):
  - `mean <= acc >> LOG2_WIN`, truncated with no rounding.
  - `max_out`, `min_out` and `vpp` are loaded.
  - `low_amp` is loaded, computed from the new `vpp`.
  - `mean_valid` is set to 1 and `locked` is set to 1.
  - `acc`, `cnt` are cleared, `run_max` is set to 0 and `run_min` to all-ones.
  - The next state is ACCUM.
  - A `sample_valid` arriving in the COMMIT cycle counts as the first sample of the next window; there are no dropped samples.
- Width rules:
  - `acc` is DATA_W+LOG2_WIN bits, so a full-scale window cannot overflow.
  - `mean` upper MEAN_W-DATA_W bits are always 0.
- Before the first commit, the outputs hold their reset values. The midscale `mean` lets `frequency` operate on a centred signal.
- Samples with `sample_valid = 0` are ignored in every state.

## Timing

Reset values, applied on the edge where `rst_n = 0`:
- `mean` = 14'h0800.
- `max_out` = 0, `min_out` = 0, `vpp` = 0.
- `mean_valid` = 0, `locked` = 0, `low_amp` = 1.
- The state machine returns to SETTLE, and `acc`, `cnt` and the settle counter clear.

Reset mid-window:
- Partial sums are discarded.
- SETTLE restarts, and `locked` drops.

Latency and output behaviour:
- Latency is 1 cycle: the last valid sample of a window is sampled on edge N; the outputs change and `mean_valid` is high in cycle N+1.
- All outputs are registered and stable between `mean_valid` pulses.
- The minimum spacing between `mean_valid` pulses is 2^LOG2_WIN cycles, reached when `sample_valid` is continuously high.

## Test plan

The bench uses `LOG2_WIN`=4, `SETTLE_N`=2 and `MIN_VPP`=64.

1. Reset check:
   - Stimulus: `rst_n` low for 3 cycles, then 2 valid samples of 0xFFF.
   - Required: `mean`=14'h0800, `locked`=0, `low_amp`=1, `mean_valid` never pulses (the samples are discarded).
2. Ramp window:
   - Stimulus: after settle, 16 continuous samples 0..15.
   - Required: one cycle after the 16th sample, `mean`=7 (120>>4), `min_out`=0, `max_out`=15, `vpp`=15, `low_amp`=1, `mean_valid`=1 for exactly 1 cycle, `locked`=1.
3. Square wave:
   - Stimulus: alternating 0x100 and 0xF00, 16 samples.
   - Required: `mean`=14'h0800, `vpp`=0xE00, `low_amp`=0.
   - Follow-on: 16 samples of constant 0x400 give `mean`=0x400, `vpp`=0, `low_amp`=1.
4. Full scale with gaps:
   - Stimulus: 16 samples of 0xFFF, each separated by 0–3 random cycles with `sample_valid`=0.
   - Required: `mean`=14'h0FFF (sum 65520, no overflow); `mean_valid` fires exactly 1 cycle after the 16th valid sample.
5. Back-to-back windows:
   - Stimulus: continuous valid stream, with a sample presented during the COMMIT cycle.
   - Required: the second window's `mean` includes that sample, and `mean_valid` pulses are exactly 16 cycles apart.
6. Reset mid-window:
   - Stimulus: assert `rst_n`=0 after 9 samples of a window.
   - Required: outputs return to reset values the next cycle; the next commit occurs only after 2 settle + 16 valid samples.

Source files
------------

// File: rtl/signal_mean_if.sv
// signal_mean_if: ADC sample stream in, per-window statistics out
interface signal_mean_if #(
  parameter int DATA_W = 12,
  parameter int MEAN_W = 14
);
  logic              sample_valid;
  logic [DATA_W-1:0] data;
  logic [MEAN_W-1:0] mean;
  logic [DATA_W-1:0] max_out;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] vpp;
  logic              mean_valid;
  logic              locked;
  logic              low_amp;
  modport master (output sample_valid, data, input mean, max_out, min_out, vpp, mean_valid, locked, low_amp);
  modport slave  (input sample_valid, data, output mean, max_out, min_out, vpp, mean_valid, locked, low_amp);
endinterface

// File: rtl/signal_mean.sv
// signal_mean: power-of-two window mean, min/max and peak-to-peak of an ADC stream
module signal_mean #(
  parameter int                DATA_W   = 12,
  parameter int                MEAN_W   = 14,
  parameter int                LOG2_WIN = 10,
  parameter int                SETTLE_N = 8,
  parameter logic [DATA_W-1:0] MIN_VPP  = DATA_W'(64)
) (
  input logic          clk,
  input logic          rst_n,
  signal_mean_if.slave bus
);
  localparam int ACC_W = DATA_W + LOG2_WIN;
  localparam int SET_W = SETTLE_N > 1 ? $clog2(SETTLE_N) : 1;
  typedef enum logic [1:0] {SETTLE, ACCUM, COMMIT} state_t;
  localparam state_t START = SETTLE_N == 0 ? ACCUM : SETTLE;
  state_t              r_state, w_next;
  logic [SET_W-1:0]    r_settle;
  logic [ACC_W-1:0]    r_acc, w_acc;
  logic [LOG2_WIN-1:0] r_cnt;
  logic [DATA_W-1:0]   r_max, r_min, w_max, w_min, w_vpp;
  logic [MEAN_W-1:0]   r_mean;
  logic [DATA_W-1:0]   r_max_out, r_min_out, r_vpp;
  logic                r_mean_valid, r_locked, r_low_amp;
  logic                w_take, w_last, w_settled;
  // sample qualification, running statistics including the current sample, next state
  always_comb begin
    w_take    = bus.sample_valid && r_state != SETTLE;
    w_last    = w_take && &r_cnt;
    w_settled = bus.sample_valid && r_settle == SET_W'(SETTLE_N - 1);
    w_acc     = r_acc + ACC_W'(bus.data);
    w_max     = bus.data > r_max ? bus.data : r_max;
    w_min     = bus.data < r_min ? bus.data : r_min;
    w_vpp     = w_max - w_min;
    w_next    = r_state == SETTLE ? (w_settled ? ACCUM : SETTLE) : (w_last ? COMMIT : ACCUM);
  end
  // state register; COMMIT is the single cycle in which fresh results are presented
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= START;
    else        r_state <= w_next;
  end
  // counts discarded samples while the ADC pipeline flushes
  always_ff @(posedge clk) begin
    if (!rst_n)                                    r_settle <= '0;
    else if (r_state == SETTLE && bus.sample_valid) r_settle <= r_settle + SET_W'(1);
  end
  // window accumulators restart on the closing sample so a COMMIT-cycle sample opens the next window
  always_ff @(posedge clk) begin
    if (!rst_n || w_last) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_max <= '0;
      r_min <= '1;
    end else if (w_take) begin
      r_acc <= w_acc;
      r_cnt <= r_cnt + LOG2_WIN'(1);
      r_max <= w_max;
      r_min <= w_min;
    end
  end
  // result registers load from the closing sample and hold until the next window completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mean       <= MEAN_W'(1 << (DATA_W - 1));
      r_max_out    <= '0;
      r_min_out    <= '0;
      r_vpp        <= '0;
      r_mean_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_low_amp    <= 1'b1;
    end else begin
      r_mean_valid <= w_last;
      if (w_last) begin
        r_mean    <= MEAN_W'(w_acc[ACC_W-1:LOG2_WIN]);
        r_max_out <= w_max;
        r_min_out <= w_min;
        r_vpp     <= w_vpp;
        r_locked  <= 1'b1;
        r_low_amp <= w_vpp < MIN_VPP;
      end
    end
  end
  assign bus.mean       = r_mean;
  assign bus.max_out    = r_max_out;
  assign bus.min_out    = r_min_out;
  assign bus.vpp        = r_vpp;
  assign bus.mean_valid = r_mean_valid;
  assign bus.locked     = r_locked;
  assign bus.low_amp    = r_low_amp;
endmodule
